// File: rtl/axi_stream_insert_header_pkg.sv
// Shared types and helpers for the AXI-Stream header inserter.
// Holds the FSM state encoding and the byte-count to keep-mask conversion.
package axi_stream_insert_header_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FLUSH
  } state_e;

  localparam int MAX_BYTES = 64;

  // Left-aligned keep mask with `cnt` ones inside a `width`-lane bus; callers truncate to width.
  function automatic logic [MAX_BYTES-1:0] keep_from_count(int cnt, int width);
    logic [MAX_BYTES-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < width && i + cnt >= width) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/axi_stream_insert_header_axis_out_reg.sv
// Output register stage: captures a beat on load and holds it stable until the
// downstream handshake; free_o tells the producer a new beat may be loaded.
module axis_out_reg #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [DATA_WD-1:0]      data_i,
  input  logic [DATA_BYTE_WD-1:0] keep_i,
  input  logic                    last_i,
  input  logic                    ready_out_i,
  output logic                    valid_o,
  output logic [DATA_WD-1:0]      data_o,
  output logic [DATA_BYTE_WD-1:0] keep_o,
  output logic                    last_o,
  output logic                    free_o
);

  logic                    valid_q;
  logic [DATA_WD-1:0]      data_q;
  logic [DATA_BYTE_WD-1:0] keep_q;
  logic                    last_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
      last_q  <= last_i;
    end else if (ready_out_i) begin
      valid_q <= 1'b0;
    end
  end

  assign free_o  = !valid_q || ready_out_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

endmodule

// File: rtl/axi_stream_insert_header.sv
// Inserts a 1..DATA_BYTE_WD byte header ahead of each AXI-Stream packet and
// re-packs the combined MSB-first byte stream onto the output bus.
module axi_stream_insert_header
  import axi_stream_insert_header_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert
);

  localparam int CNT_WD = BYTE_CNT_WD + 1;
  localparam int SUM_WD = BYTE_CNT_WD + 2;
  localparam int SH_W   = $clog2(DATA_WD) + 1;

  function automatic logic [DATA_WD-1:0] byte_mask(logic [DATA_BYTE_WD-1:0] keep);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

  state_e             state_q, state_d;
  logic [DATA_WD-1:0] res_q, res_d;
  logic [CNT_WD-1:0]  h_q, h_d;
  logic [CNT_WD-1:0]  rem_q, rem_d;

  logic                    ld_valid, ld_last, out_free;
  logic [DATA_WD-1:0]      ld_data;
  logic [DATA_BYTE_WD-1:0] ld_keep;

  // Header length only matters via byte_insert_cnt; keep_insert is carried for the source's benefit.
  logic unused_keep_insert;
  assign unused_keep_insert = ^keep_insert;

  logic [CNT_WD-1:0]       h_new, n_in;
  logic [SUM_WD-1:0]       total, total_rem;
  logic [SH_W-1:0]         sh_h, sh_keep_h, sh_new_keep;
  logic [DATA_WD-1:0]      beat_data;
  logic [DATA_BYTE_WD-1:0] keep_total, keep_rem, keep_flush;

  assign h_new       = (byte_insert_cnt == '0) ? CNT_WD'(DATA_BYTE_WD) : {1'b0, byte_insert_cnt};
  assign n_in        = CNT_WD'($countones(keep_in));
  assign total       = SUM_WD'(h_q) + SUM_WD'(n_in);
  assign total_rem   = total - SUM_WD'(DATA_BYTE_WD);
  assign sh_h        = SH_W'(h_q) << 3;
  assign sh_keep_h   = SH_W'(DATA_WD) - sh_h;
  assign sh_new_keep = SH_W'(DATA_WD) - (SH_W'(h_new) << 3);
  // Residual sits right-aligned in DATA: it leads the beat, followed by the top bytes of data_in.
  assign beat_data   = (res_q << sh_keep_h) | (data_in >> sh_h);
  assign keep_total  = DATA_BYTE_WD'(keep_from_count(int'(total), DATA_BYTE_WD));
  assign keep_rem    = DATA_BYTE_WD'(keep_from_count(int'(total_rem), DATA_BYTE_WD));
  assign keep_flush  = DATA_BYTE_WD'(keep_from_count(int'(rem_q), DATA_BYTE_WD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      h_q     <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      h_q     <= h_d;
      rem_q   <= rem_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    res_d        = res_q;
    h_d          = h_q;
    rem_d        = rem_q;
    ready_in     = 1'b0;
    ready_insert = 1'b0;
    ld_valid     = 1'b0;
    ld_data      = '0;
    ld_keep      = '0;
    ld_last      = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_insert = 1'b1;
        if (valid_insert) begin
          res_d   = data_insert & ({DATA_WD{1'b1}} >> sh_new_keep);
          h_d     = h_new;
          state_d = DATA;
        end
      end
      DATA: begin
        ready_in = out_free;
        if (valid_in && out_free) begin
          ld_valid = 1'b1;
          ld_data  = beat_data;
          ld_keep  = '1;
          res_d    = data_in & ({DATA_WD{1'b1}} >> sh_keep_h);
          if (last_in) begin
            if (total <= SUM_WD'(DATA_BYTE_WD)) begin
              ld_keep = keep_total;
              ld_data = beat_data & byte_mask(keep_total);
              ld_last = 1'b1;
              res_d   = '0;
              state_d = IDLE;
            end else begin
              // In FLUSH the residual is held left-aligned and already zero-padded.
              res_d   = (data_in << sh_keep_h) & byte_mask(keep_rem);
              rem_d   = CNT_WD'(total_rem);
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          ld_valid = 1'b1;
          ld_data  = res_q;
          ld_keep  = keep_flush;
          ld_last  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  axis_out_reg #(
    .DATA_WD     (DATA_WD),
    .DATA_BYTE_WD(DATA_BYTE_WD)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ld_valid),
    .data_i     (ld_data),
    .keep_i     (ld_keep),
    .last_i     (ld_last),
    .ready_out_i(ready_out),
    .valid_o    (valid_out),
    .data_o     (data_out),
    .keep_o     (keep_out),
    .last_o     (last_out),
    .free_o     (out_free)
  );

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Self-checking bench: every packet is modelled as a plain byte queue (header
// bytes then payload bytes) chopped into output beats and scoreboarded.
module tb_axi_stream_insert_header;

  localparam int DW = 32;
  localparam int DB = DW / 8;
  localparam int CW = $clog2(DB);

  logic          clk, rst_n;
  logic          valid_in, last_in, ready_in;
  logic [DW-1:0] data_in;
  logic [DB-1:0] keep_in;
  logic          valid_out, last_out, ready_out;
  logic [DW-1:0] data_out;
  logic [DB-1:0] keep_out;
  logic          valid_insert, ready_insert;
  logic [DW-1:0] data_insert;
  logic [DB-1:0] keep_insert;
  logic [CW-1:0] byte_insert_cnt;

  axi_stream_insert_header #(.DATA_WD(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .keep_in        (keep_in),
    .last_in        (last_in),
    .ready_in       (ready_in),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .keep_out       (keep_out),
    .last_out       (last_out),
    .ready_out      (ready_out),
    .valid_insert   (valid_insert),
    .data_insert    (data_insert),
    .keep_insert    (keep_insert),
    .byte_insert_cnt(byte_insert_cnt),
    .ready_insert   (ready_insert)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [DB-1:0] keep;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] pkt_data[$];
  logic [DB-1:0] pkt_keep[$];
  int            n_checks = 0;
  int            n_errors = 0;
  bit            mon_en   = 1'b1;
  bit            rand_rdy = 1'b0;
  bit            rdy_val  = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_out = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end

  beat_t mon_e;
  always @(negedge clk) begin
    if (mon_en && rst_n && valid_out && ready_out) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", data_out, mon_e.data);
        check("keep_out", keep_out, mon_e.keep);
        check("last_out", last_out, mon_e.last);
      end
    end
  end

  // Reference: header's low h bytes (MSB first), then each beat's valid bytes, re-chunked.
  task automatic model_packet(input int h, input logic [DW-1:0] ins);
    logic [7:0] bq[$];
    for (int i = h - 1; i >= 0; i--) bq.push_back(ins[8*i +: 8]);
    for (int b = 0; b < pkt_data.size(); b++) begin
      logic [DW-1:0] d;
      d = pkt_data[b];
      for (int j = 0; j < $countones(pkt_keep[b]); j++) bq.push_back(d[8*(DB-1-j) +: 8]);
    end
    while (bq.size() > 0) begin
      beat_t e;
      e.data = '0;
      e.keep = '0;
      for (int j = 0; j < DB && bq.size() > 0; j++) begin
        e.data[8*(DB-1-j) +: 8] = bq.pop_front();
        e.keep[DB-1-j] = 1'b1;
      end
      e.last = (bq.size() == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_header(input int h, input logic [DW-1:0] ins);
    bit acc;
    valid_insert    = 1'b1;
    data_insert     = ins;
    byte_insert_cnt = CW'(h % DB);
    keep_insert     = DB'({DB{1'b1}} >> (DB - h));
    for (int t = 0; ; t++) begin
      @(negedge clk);
      acc = ready_insert;
      @(posedge clk);
      #1;
      if (acc) break;
      if (t > 200) begin
        check("header_timeout", 0, 1);
        break;
      end
    end
    valid_insert = 1'b0;
    data_insert  = $urandom;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l);
    bit acc;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
      if (acc) break;
      if (t > 200) begin
        check("beat_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic send_packet(input int h, input logic [DW-1:0] ins, input bit gaps);
    model_packet(h, ins);
    drive_header(h, ins);
    for (int b = 0; b < pkt_data.size(); b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        valid_in = 1'b0;
        @(posedge clk);
        #1;
      end
      drive_beat(pkt_data[b], pkt_keep[b], b == pkt_data.size() - 1);
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  // Random payload; last beat carries junk in its disabled lanes to exercise zeroing.
  task automatic gen_payload(input int nbeats);
    int n;
    pkt_data.delete();
    pkt_keep.delete();
    for (int b = 0; b < nbeats; b++) begin
      pkt_data.push_back($urandom);
      n = (b == nbeats - 1) ? $urandom_range(1, DB) : DB;
      pkt_keep.push_back(DB'({DB{1'b1}} << (DB - n)));
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_remaining", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] snap_d;
  logic [DB-1:0] snap_k;
  logic          snap_l;

  initial begin
    rst_n = 1'b0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
    repeat (3) @(negedge clk);
    check("rst_valid_out", valid_out, 0);
    check("rst_last_out", last_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_keep_out", keep_out, 0);
    check("rst_ready_in", ready_in, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready_insert", ready_insert, 1);

    // Input offered with no header: must stall.
    valid_in = 1'b1; data_in = 32'h11223344; keep_in = '1; last_in = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("nohdr_ready_in", ready_in, 0);
      check("nohdr_valid_out", valid_out, 0);
    end
    @(posedge clk); #1;

    pkt_data = '{32'h11223344, 32'h55667788}; pkt_keep = '{4'b1111, 4'b1111};
    send_packet(2, 32'h0000AABB, 1'b0);
    pkt_data = '{32'h01020304}; pkt_keep = '{4'b1110};
    send_packet(4, 32'hDEADBEEF, 1'b0);
    pkt_data = '{32'h11223344}; pkt_keep = '{4'b1110};
    send_packet(1, 32'h000000CC, 1'b0);
    wait_drain();

    // Downstream stall mid-packet: output must hold and input must block.
    gen_payload(4);
    pkt_keep[3] = '1;
    fork
      send_packet(3, $urandom, 1'b0);
      begin
        for (int t = 0; t < 200 && !valid_out; t++) @(negedge clk);
        rdy_val = 1'b0;
        @(negedge clk);
        check("stall_valid_out", valid_out, 1);
        snap_d = data_out; snap_k = keep_out; snap_l = last_out;
        repeat (3) begin
          @(negedge clk);
          check("stall_data_hold", data_out, snap_d);
          check("stall_keep_hold", keep_out, snap_k);
          check("stall_last_hold", last_out, snap_l);
          check("stall_ready_in", ready_in, 0);
        end
        rdy_val = 1'b1;
      end
    join
    wait_drain();

    rand_rdy = 1'b1;
    for (int p = 0; p < 30; p++) begin
      gen_payload($urandom_range(1, 4));
      send_packet($urandom_range(1, DB), $urandom, 1'b1);
    end
    wait_drain();
    rand_rdy = 1'b0;
    rdy_val  = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a packet aborts it.
    mon_en = 1'b0;
    drive_header(2, $urandom);
    drive_beat($urandom, '1, 1'b0);
    drive_beat($urandom, '1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", valid_out, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_keep_out", keep_out, 0);
    check("midrst_last_out", last_out, 0);
    check("midrst_ready_in", ready_in, 0);
    valid_in = 1'b0;
    exp_q.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("postrst_ready_insert", ready_insert, 1);
    @(posedge clk); #1;
    pkt_data = '{32'h11223344, 32'h55667788}; pkt_keep = '{4'b1111, 4'b1111};
    send_packet(2, 32'h0000AABB, 1'b0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL global_timeout: got=running expected=finished");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
